// File: rtl/vrs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vrs_pkg
// Brief   : Shared rate encodings, fetch FSM state codes and rate helpers
// Revision: 1.0 - initial release
// ============================================================================
package vrs_pkg;

    typedef enum logic [2:0] {
        RATE_1X1 = 3'd0,
        RATE_1X2 = 3'd1,
        RATE_2X2 = 3'd2,
        RATE_3X3 = 3'd3,
        RATE_4X4 = 3'd4
    } rate_e;

    localparam logic [2:0] RATE_MAX = 3'd4;

    typedef logic [1:0] fetch_state_e;
    localparam fetch_state_e IDLE = 2'd0;
    localparam fetch_state_e REQ  = 2'd1;
    localparam fetch_state_e WAIT = 2'd2;
    localparam fetch_state_e OUT  = 2'd3;

    // Encodings 5..7 are not legal rates; treat them as the coarsest rate.
    function automatic logic [2:0] clamp_rate(input logic [2:0] v);
        return (v > RATE_MAX) ? RATE_MAX : v;
    endfunction

    function automatic logic [2:0] max_rate(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vrs_rate_tag_cache.sv
`default_nettype none
// ============================================================================
// Module  : vrs_rate_tag_cache
// Brief   : Fully-associative tile-rate cache, round-robin fill, flash flush
// Revision: 1.0 - initial release
// ============================================================================
module vrs_rate_tag_cache
    import vrs_pkg::*;
#(
    parameter int TAG_W   = 24,
    parameter int ENTRIES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] i_lookup_tag,
    output logic             o_lookup_hit,
    output logic [2:0]       o_lookup_rate,
    input  logic             i_fill_en,
    input  logic [TAG_W-1:0] i_fill_tag,
    input  logic [2:0]       i_fill_rate,
    input  logic             i_invalidate
);

    localparam int c_ptr_w = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [TAG_W-1:0]   r_tag  [ENTRIES];
    logic [2:0]         r_rate [ENTRIES];
    logic [ENTRIES-1:0] r_valid;
    logic [c_ptr_w-1:0] r_ptr;
    logic [ENTRIES-1:0] w_match;
    logic               w_write;

    generate
        for (genvar i = 0; i < ENTRIES; i++) begin : g_match
            assign w_match[i] = r_valid[i] && (r_tag[i] == i_lookup_tag);
        end
    endgenerate

    always_comb begin
        o_lookup_hit  = |w_match;
        o_lookup_rate = RATE_1X1;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_match[i]) o_lookup_rate = r_rate[i];
        end
    end

    // A flush in the same cycle as a fill discards the fill.
    assign w_write = i_fill_en && !i_invalidate;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_ptr   <= '0;
        end else if (i_invalidate) begin
            r_valid <= '0;
            r_ptr   <= '0;
        end else if (w_write) begin
            r_valid[r_ptr] <= 1'b1;
            r_ptr          <= r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_tag[r_ptr]  <= i_fill_tag;
            r_rate[r_ptr] <= i_fill_rate;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vrs_rate_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : vrs_rate_fetch_ctrl
// Brief   : Per-fragment shading-rate resolve via tile cache + image lookup.
//           VRS_FETCH_COMBINER_EN adds draw_rate, combined coarsest-wins.
// Revision: 1.0 - initial release
// ============================================================================
module vrs_rate_fetch_ctrl
    import vrs_pkg::*;
#(
    parameter int TILE_SHIFT     = 4,
    parameter int CACHE_ENTRIES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frag_in_valid,
    output logic        frag_in_ready,
    input  logic [15:0] frag_x,
    input  logic [15:0] frag_y,
    input  logic        invalidate,
`ifdef VRS_FETCH_COMBINER_EN
    input  logic [2:0]  draw_rate,
`endif
    output logic        img_req,
    output logic [15:0] img_x,
    output logic [15:0] img_y,
    input  logic [2:0]  img_value,
    input  logic        img_valid,
    output logic        frag_out_valid,
    input  logic        frag_out_ready,
    output logic [15:0] frag_out_x,
    output logic [15:0] frag_out_y,
    output logic [2:0]  frag_out_rate,
    output logic        err_timeout,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses,
    output logic [31:0] perf_timeouts
);

    localparam int               c_tag_w     = 2 * (16 - TILE_SHIFT);
    localparam int               c_tmo_w     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]      c_tile_mask = ~((16'd1 << TILE_SHIFT) - 16'd1);

    fetch_state_e       r_state, w_next;
    logic [15:0]        r_frag_x, r_frag_y, r_img_x, r_img_y;
    logic [15:0]        r_out_x, r_out_y;
    logic [2:0]         r_draw, r_rate, r_out_rate;
    logic               r_out_valid, r_err_timeout, r_flushed;
    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic [31:0]        r_hits, r_misses, r_timeouts;

    logic               w_accept, w_hit, w_out_free, w_tmo, w_resp;
    logic               w_hit_load, w_out_load, w_fill_en, w_img_req;
    logic [2:0]         w_hit_rate, w_draw_now;
    logic [c_tag_w-1:0] w_lookup_tag, w_fill_tag;

`ifdef VRS_FETCH_COMBINER_EN
    assign w_draw_now = clamp_rate(draw_rate);
`else
    assign w_draw_now = RATE_1X1;
`endif

    assign w_out_free   = !r_out_valid || frag_out_ready;
    assign w_accept     = frag_in_valid && frag_in_ready;
    assign w_lookup_tag = {frag_x[15:TILE_SHIFT], frag_y[15:TILE_SHIFT]};
    assign w_fill_tag   = {r_frag_x[15:TILE_SHIFT], r_frag_y[15:TILE_SHIFT]};

    vrs_rate_tag_cache #(
        .TAG_W   (c_tag_w),
        .ENTRIES (CACHE_ENTRIES)
    ) u_cache (
        .clk           (clk),
        .rst           (rst),
        .i_lookup_tag  (w_lookup_tag),
        .o_lookup_hit  (w_hit),
        .o_lookup_rate (w_hit_rate),
        .i_fill_en     (w_fill_en),
        .i_fill_tag    (w_fill_tag),
        .i_fill_rate   (clamp_rate(img_value)),
        .i_invalidate  (invalidate)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_hit) w_next = REQ;
            REQ:     w_next = WAIT;
            WAIT:    if (img_valid || w_tmo) w_next = OUT;
            OUT:     if (w_out_free) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        frag_in_ready = (r_state == IDLE) && w_out_free;
        w_img_req     = (r_state == REQ);
        w_resp        = (r_state == WAIT) && img_valid;
        w_tmo         = (r_state == WAIT) && !img_valid && (r_tmo_cnt == c_tmo_last);
        // A response to a lookup that straddled a flush belongs to the old image.
        w_fill_en     = w_resp && !r_flushed;
        w_hit_load    = (r_state == IDLE) && w_accept && w_hit;
        w_out_load    = w_hit_load || ((r_state == OUT) && w_out_free);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frag_x      <= '0;
            r_frag_y      <= '0;
            r_img_x       <= '0;
            r_img_y       <= '0;
            r_draw        <= '0;
            r_rate        <= '0;
            r_flushed     <= 1'b0;
            r_tmo_cnt     <= '0;
            r_err_timeout <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_x       <= '0;
            r_out_y       <= '0;
            r_out_rate    <= '0;
            r_hits        <= '0;
            r_misses      <= '0;
            r_timeouts    <= '0;
        end else begin
            r_err_timeout <= w_tmo;
            if (w_accept) begin
                r_frag_x <= frag_x;
                r_frag_y <= frag_y;
                r_draw   <= w_draw_now;
            end
            if (w_accept && !w_hit) begin
                r_img_x   <= frag_x & c_tile_mask;
                r_img_y   <= frag_y & c_tile_mask;
                r_flushed <= 1'b0;
                r_misses  <= r_misses + 32'd1;
            end else if (invalidate && (r_state == REQ || r_state == WAIT)) begin
                r_flushed <= 1'b1;
            end
            if (w_hit_load) r_hits <= r_hits + 32'd1;
            if (w_tmo)      r_timeouts <= r_timeouts + 32'd1;

            if (r_state == REQ)       r_tmo_cnt <= '0;
            else if (r_state == WAIT) r_tmo_cnt <= r_tmo_cnt + 1'b1;

            if (w_resp)     r_rate <= max_rate(clamp_rate(img_value), r_draw);
            else if (w_tmo) r_rate <= max_rate(RATE_1X1, r_draw);

            if (w_out_load) begin
                r_out_valid <= 1'b1;
                r_out_x     <= w_hit_load ? frag_x : r_frag_x;
                r_out_y     <= w_hit_load ? frag_y : r_frag_y;
                r_out_rate  <= w_hit_load ? max_rate(w_hit_rate, w_draw_now) : r_rate;
            end else if (frag_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign img_req        = w_img_req;
    assign img_x          = r_img_x;
    assign img_y          = r_img_y;
    assign frag_out_valid = r_out_valid;
    assign frag_out_x     = r_out_x;
    assign frag_out_y     = r_out_y;
    assign frag_out_rate  = r_out_rate;
    assign err_timeout    = r_err_timeout;
    assign perf_hits      = r_hits;
    assign perf_misses    = r_misses;
    assign perf_timeouts  = r_timeouts;

endmodule
`default_nettype wire

// File: tb/tb_vrs_rate_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_vrs_rate_fetch_ctrl
// Brief   : Directed self-checking bench for vrs_rate_fetch_ctrl
// Revision: 1.0 - initial release
// ============================================================================
module tb_vrs_rate_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frag_in_valid, frag_in_ready;
    logic [15:0] frag_x, frag_y;
    logic        invalidate;
    logic [2:0]  draw_rate;
    logic        img_req;
    logic [15:0] img_x, img_y;
    logic [2:0]  img_value;
    logic        img_valid;
    logic        frag_out_valid, frag_out_ready;
    logic [15:0] frag_out_x, frag_out_y;
    logic [2:0]  frag_out_rate;
    logic        err_timeout;
    logic [31:0] perf_hits, perf_misses, perf_timeouts;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int req_cnt  = 0;
    int tmo_pulses = 0;

    vrs_rate_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .frag_in_valid  (frag_in_valid),
        .frag_in_ready  (frag_in_ready),
        .frag_x         (frag_x),
        .frag_y         (frag_y),
        .invalidate     (invalidate),
`ifdef VRS_FETCH_COMBINER_EN
        .draw_rate      (draw_rate),
`endif
        .img_req        (img_req),
        .img_x          (img_x),
        .img_y          (img_y),
        .img_value      (img_value),
        .img_valid      (img_valid),
        .frag_out_valid (frag_out_valid),
        .frag_out_ready (frag_out_ready),
        .frag_out_x     (frag_out_x),
        .frag_out_y     (frag_out_y),
        .frag_out_rate  (frag_out_rate),
        .err_timeout    (err_timeout),
        .perf_hits      (perf_hits),
        .perf_misses    (perf_misses),
        .perf_timeouts  (perf_timeouts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (img_req)     req_cnt++;
        if (err_timeout) tmo_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frag(input logic [15:0] x, input logic [15:0] y);
        frag_in_valid = 1'b1;
        frag_x = x;
        frag_y = y;
        for (int i = 0; i < 200; i++) begin
            if (frag_in_ready) begin
                tick();
                frag_in_valid = 1'b0;
                return;
            end
            tick();
        end
        frag_in_valid = 1'b0;
        check_eq("accept_bound", 0, 1);
    endtask

    task automatic expect_out(input logic [15:0] x, input logic [15:0] y, input logic [2:0] rate, input string tag);
        for (int i = 0; i < 20 && !frag_out_valid; i++) tick();
        check_eq({tag, "_valid"}, frag_out_valid, 1);
        check_eq({tag, "_x"}, frag_out_x, x);
        check_eq({tag, "_y"}, frag_out_y, y);
        check_eq({tag, "_rate"}, frag_out_rate, rate);
        tick();
    endtask

    // Miss: expect one aligned request, answer one cycle later, check the result.
    task automatic do_miss(input logic [15:0] x, input logic [15:0] y, input logic [2:0] v,
                           input logic [2:0] exp_rate, input string tag);
        send_frag(x, y);
        check_eq({tag, "_req"}, img_req, 1);
        check_eq({tag, "_imgx"}, img_x, x & 16'hfff0);
        check_eq({tag, "_imgy"}, img_y, y & 16'hfff0);
        tick();
        img_valid = 1'b1;
        img_value = v;
        tick();
        img_valid = 1'b0;
        expect_out(x, y, exp_rate, tag);
    endtask

    logic [15:0] tile_x [4] = '{16'd16, 16'd32, 16'd48, 16'd67};
    logic [2:0]  tile_v [4] = '{3'd1, 3'd3, 3'd0, 3'd4};

    initial begin
        int a;
        rst = 1'b1;
        frag_in_valid = 0; frag_x = 0; frag_y = 0; invalidate = 0; draw_rate = 0;
        img_value = 0; img_valid = 0; frag_out_ready = 1'b1;
        repeat (3) tick();
        check_eq("rst_out_valid", frag_out_valid, 0);
        check_eq("rst_img_req", img_req, 0);
        check_eq("rst_err", err_timeout, 0);
        check_eq("rst_hits", perf_hits, 0);
        check_eq("rst_misses", perf_misses, 0);
        check_eq("rst_timeouts", perf_timeouts, 0);
        rst = 1'b0;
        tick();
        check_eq("idle_ready", frag_in_ready, 1);

        // First miss on tile (0,0)
        do_miss(16'd5, 16'd9, 3'd2, 3'd2, "m0");
        check_eq("m0_misses", perf_misses, 1);
        check_eq("m0_reqs", req_cnt, 1);

        // Hit: output one cycle after accept, no request
        send_frag(16'd15, 16'd3);
        check_eq("h0_valid", frag_out_valid, 1);
        check_eq("h0_rate", frag_out_rate, 2);
        check_eq("h0_noreq", img_req, 0);
        tick();
        check_eq("h0_hits", perf_hits, 1);
        check_eq("h0_reqs", req_cnt, 1);

        // Fill the remaining entries then evict (0,0)
        send_frag(16'd0, 16'd0);
        check_eq("h1_rate", frag_out_rate, 2);
        tick();
        for (int i = 0; i < 4; i++)
            do_miss(tile_x[i], 16'd5, tile_v[i], tile_v[i], $sformatf("fill%0d", i));
        do_miss(16'd3, 16'd3, 3'd2, 3'd2, "evict");
        check_eq("evict_misses", perf_misses, 6);
        check_eq("evict_hits", perf_hits, 2);

        // Timeout path, then a late response that must be ignored
        send_frag(16'd200, 16'd200);
        a = cyc;
        for (int i = 0; i < 100 && !err_timeout; i++) tick();
        check_eq("tmo_seen", err_timeout, 1);
        check_eq("tmo_delay", cyc - (a + 1), 64);
        img_valid = 1'b1;
        img_value = 3'd3;
        tick();
        img_valid = 1'b0;
        expect_out(16'd200, 16'd200, 3'd0, "tmo");
        check_eq("tmo_count", perf_timeouts, 1);
        check_eq("tmo_pulses", tmo_pulses, 1);
        do_miss(16'd200, 16'd200, 3'd1, 3'd1, "tmo_again");

        // Clamp 7->4 with downstream stalled for 10 cycles
        frag_out_ready = 1'b0;
        send_frag(16'd300, 16'd0);
        check_eq("stall_req", img_req, 1);
        tick();
        img_valid = 1'b1;
        img_value = 3'd7;
        tick();
        img_valid = 1'b0;
        for (int i = 0; i < 20 && !frag_out_valid; i++) tick();
        frag_in_valid = 1'b1;
        frag_x = 16'd5;
        frag_y = 16'd9;
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("stall_inrdy%0d", i), frag_in_ready, 0);
            check_eq($sformatf("stall_rate%0d", i), frag_out_rate, 4);
            check_eq($sformatf("stall_x%0d", i), frag_out_x, 300);
            tick();
        end
        check_eq("stall_valid", frag_out_valid, 1);
        check_eq("stall_hits", perf_hits, 2);
        frag_out_ready = 1'b1;
        #0;
        check_eq("drain_inrdy", frag_in_ready, 1);
        tick();
        frag_in_valid = 1'b0;
        check_eq("b2b_valid", frag_out_valid, 1);
        check_eq("b2b_x", frag_out_x, 5);
        check_eq("b2b_rate", frag_out_rate, 2);
        tick();

        // Invalidate during WAIT: fragment resolved, result not cached
        send_frag(16'd1, 16'd17);
        check_eq("inv_req", img_req, 1);
        check_eq("inv_imgy", img_y, 16);
        tick();
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        img_valid = 1'b1;
        img_value = 3'd3;
        tick();
        img_valid = 1'b0;
        expect_out(16'd1, 16'd17, 3'd3, "inv");
        do_miss(16'd2, 16'd18, 3'd5, 3'd4, "inv_same");
        do_miss(16'd5, 16'd9, 3'd2, 3'd2, "inv_old");
        check_eq("fin_misses", perf_misses, 12);
        check_eq("fin_hits", perf_hits, 3);
        check_eq("fin_timeouts", perf_timeouts, 1);
        check_eq("fin_reqs", req_cnt, 12);

`ifdef VRS_FETCH_COMBINER_EN
        draw_rate = 3'd4;
        send_frag(16'd6, 16'd6);
        check_eq("comb_valid", frag_out_valid, 1);
        check_eq("comb_rate", frag_out_rate, 4);
        draw_rate = 3'd0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
